sensor_acq_sched: RTL and testbench

Frame-level acquisition scheduler for the line sensor. Runs in the `clk_100M` domain and derives the 4 MHz sensor tick internally with a clock-enable, so no second clock is needed. Each frame is sequenced as sensor reset, then integration, then pixel readout, then an inter-frame gap. It drives the `count`, `data_count`, `cycle_count`, `sen_rst` and `acq_timing` signals consumed by the sensor front end and the pixel buffer.

---
 rtl/sensor_acq_pkg.sv | 20 ++
 rtl/acq_prescaler.sv | 33 +++
 rtl/sensor_acq_sched.sv | 154 +++++++++++++++
 tb/tb_sensor_acq_sched.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_acq_pkg.sv
// rtl/sensor_acq_pkg.sv - shared state encoding, default timing constants and counter widths
package sensor_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_INTEG   = 3'd2,
    ST_READOUT = 3'd3,
    ST_GAP     = 3'd4
  } acq_state_e;

  localparam int DEF_CLK_DIV   = 25;
  localparam int DEF_RST_TICKS = 16;
  localparam int DEF_PIXELS    = 512;
  localparam int DEF_GAP_TICKS = 8;

  localparam int COUNT_W  = 11;
  localparam int DCOUNT_W = 9;

endpackage

// File: rtl/acq_prescaler.sv
// rtl/acq_prescaler.sv - sensor tick clock-enable generator, held at zero while disabled
module acq_prescaler
  import sensor_acq_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_100M,
  input  logic sys_rst,
  input  logic en,
  output logic tick,
  output logic tick_next
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic [7:0] cnt_n;

  assign cnt_n     = !en ? 8'd0 : ((cnt == LAST) ? 8'd0 : cnt + 8'd1);
  assign tick      = (cnt == LAST);
  // tick_next lets the parent register outputs that must line up with the tick itself
  assign tick_next = (cnt_n == LAST);

  // divider counter: wraps at CLK_DIV-1, parked at zero when not enabled
  always_ff @(posedge clk_100M) begin
    if (sys_rst) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt_n;
    end
  end

endmodule

// File: rtl/sensor_acq_sched.sv
// rtl/sensor_acq_sched.sv - frame scheduler (reset/integrate/readout/gap); SENSOR_ACQ_OVERRUN_EN adds overrun detection
module sensor_acq_sched
  import sensor_acq_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int RST_TICKS = DEF_RST_TICKS,
  parameter int PIXELS    = DEF_PIXELS,
  parameter int GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic        clk_100M,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frames,
  input  logic [10:0] int_ticks,
  input  logic        buf_ready,
  output logic        busy,
  output logic        sen_rst,
  output logic        acq_timing,
  output logic        pix_strobe,
  output logic [10:0] count,
  output logic [8:0]  data_count,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        overrun
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RESET   = ST_RESET;
  localparam logic [2:0] S_INTEG   = ST_INTEG;
  localparam logic [2:0] S_READOUT = ST_READOUT;
  localparam logic [2:0] S_GAP     = ST_GAP;

  localparam logic [COUNT_W-1:0] RST_LAST = COUNT_W'(RST_TICKS - 1);
  localparam logic [COUNT_W-1:0] PIX_LAST = COUNT_W'(PIXELS - 1);
  localparam logic [COUNT_W-1:0] GAP_LAST = COUNT_W'(GAP_TICKS - 1);

  logic [2:0]         state;
  logic [2:0]         state_n;
  logic [15:0]        frames_q;
  logic [COUNT_W-1:0] int_last_q;
  logic               stop_pending;
  logic               tick;
  logic               tick_next;
  logic               accept;
  logic [COUNT_W-1:0] phase_last;
  logic               phase_end;
  logic [31:0]        cycle_inc;
  logic               finish;

  assign accept = (state == S_IDLE) && start;

  acq_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk_100M  (clk_100M),
    .sys_rst   (sys_rst),
    .en        (state != S_IDLE),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // phase terminal detection and next-state selection
  always_comb begin
    phase_last = RST_LAST;
    case (state)
      S_INTEG:   phase_last = int_last_q;
      S_READOUT: phase_last = PIX_LAST;
      S_GAP:     phase_last = GAP_LAST;
      default:   phase_last = RST_LAST;
    endcase
    phase_end = tick && (count == phase_last);
    cycle_inc = cycle_count + 32'd1;
    // a stop arriving on the final gap tick still ends this frame
    finish    = stop_pending || stop || ((frames_q != 16'd0) && (cycle_inc == {16'd0, frames_q}));
    state_n   = state;
    case (state)
      S_IDLE:    if (start)     state_n = S_RESET;
      S_RESET:   if (phase_end) state_n = S_INTEG;
      S_INTEG:   if (phase_end) state_n = S_READOUT;
      S_READOUT: if (phase_end) state_n = S_GAP;
      S_GAP:     if (phase_end) state_n = finish ? S_IDLE : S_RESET;
      default:   state_n = S_IDLE;
    endcase
  end

  // state, counters and registered phase outputs
  always_ff @(posedge clk_100M) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      frames_q     <= 16'd0;
      int_last_q   <= '0;
      stop_pending <= 1'b0;
      busy         <= 1'b0;
      sen_rst      <= 1'b0;
      acq_timing   <= 1'b0;
      pix_strobe   <= 1'b0;
      count        <= '0;
      data_count   <= '0;
      cycle_count  <= 32'd0;
      done         <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != S_IDLE);
      sen_rst    <= (state_n == S_RESET);
      acq_timing <= (state_n == S_READOUT);
      // strobe is registered one cycle early so it coincides with the readout tick
      pix_strobe <= (state_n == S_READOUT) && tick_next;
      done       <= (state == S_GAP) && (state_n == S_IDLE);

      if (state_n != state) begin
        count <= '0;
      end else if (tick) begin
        count <= count + 1'b1;
      end

      if ((state == S_INTEG) && (state_n == S_READOUT)) begin
        data_count <= '0;
      end else if ((state == S_READOUT) && tick && !phase_end) begin
        data_count <= count[DCOUNT_W-1:0] + 1'b1;
      end

      if (accept) begin
        cycle_count <= 32'd0;
      end else if ((state == S_GAP) && phase_end) begin
        cycle_count <= cycle_inc;
      end

      if (accept) begin
        frames_q     <= frames;
        int_last_q   <= (int_ticks == 11'd0) ? 11'd0 : int_ticks - 11'd1;
        stop_pending <= stop;
      end else if ((state != S_IDLE) && stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

`ifdef SENSOR_ACQ_OVERRUN_EN
  // sticky overrun: a pixel was presented while the buffer could not take it
  always_ff @(posedge clk_100M) begin
    if (sys_rst) begin
      overrun <= 1'b0;
    end else if (accept) begin
      overrun <= 1'b0;
    end else if (pix_strobe && !buf_ready) begin
      overrun <= 1'b1;
    end
  end
`else
  logic unused_buf_ready;
  assign unused_buf_ready = buf_ready;
  assign overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_acq_sched.sv
// tb/tb_sensor_acq_sched.sv - self-checking bench for sensor_acq_sched
module tb_sensor_acq_sched;

  localparam int TB_DIV = 4;
  localparam int TB_RST = 2;
  localparam int TB_PIX = 8;
  localparam int TB_GAP = 1;
`ifdef SENSOR_ACQ_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  typedef struct {
    logic [15:0] frames;
    logic [10:0] int_ticks;
    logic        stop_w_start;
    int          stop_frame;
    logic        poke;
    int          exp_cc;
    int          exp_len;
  } vec_t;

  typedef struct {
    longint start_cyc;
    int     cc;
    int     len;
    logic   ovr;
  } exp_t;

  logic        clk;
  logic        sys_rst;
  logic        start, stop, buf_ready;
  logic [15:0] frames;
  logic [10:0] int_ticks;
  logic        busy, sen_rst, acq_timing, pix_strobe, done, overrun;
  logic [10:0] count;
  logic [8:0]  data_count;
  logic [31:0] cycle_count;

  logic        start2;
  logic [15:0] frames2;
  logic [10:0] int_ticks2;
  logic        busy2, sen_rst2, acq_timing2, pix_strobe2, done2, overrun2;
  logic [10:0] count2;
  logic [8:0]  data_count2;
  logic [31:0] cycle_count2;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  exp_t   sb_q[$];
  int     sen_n = 0, acq_n = 0, strb_n = 0, pix_idx = 0;

  sensor_acq_sched #(.CLK_DIV(TB_DIV), .RST_TICKS(TB_RST), .PIXELS(TB_PIX), .GAP_TICKS(TB_GAP)) dut (
    .clk_100M(clk), .sys_rst(sys_rst), .start(start), .stop(stop), .frames(frames),
    .int_ticks(int_ticks), .buf_ready(buf_ready), .busy(busy), .sen_rst(sen_rst),
    .acq_timing(acq_timing), .pix_strobe(pix_strobe), .count(count), .data_count(data_count),
    .cycle_count(cycle_count), .done(done), .overrun(overrun)
  );

  sensor_acq_sched dut_def (
    .clk_100M(clk), .sys_rst(sys_rst), .start(start2), .stop(1'b0), .frames(frames2),
    .int_ticks(int_ticks2), .buf_ready(1'b1), .busy(busy2), .sen_rst(sen_rst2),
    .acq_timing(acq_timing2), .pix_strobe(pix_strobe2), .count(count2), .data_count(data_count2),
    .cycle_count(cycle_count2), .done(done2), .overrun(overrun2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pixel order, phase durations and end-of-run scoreboard
  always @(negedge clk) begin
    if (sys_rst) begin
      sen_n = 0; acq_n = 0; strb_n = 0; pix_idx = 0;
    end else begin
      if (sen_rst) sen_n++;
      if (acq_timing) acq_n++;
      if (pix_strobe) begin
        check("pix_index", data_count, pix_idx);
        pix_idx = (pix_idx + 1) % TB_PIX;
        strb_n++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("done_cycle_count", cycle_count, e.cc);
          check("done_latency", cyc - e.start_cyc, e.len);
          check("sen_rst_cycles", sen_n, e.cc * TB_RST * TB_DIV);
          check("acq_timing_cycles", acq_n, e.cc * TB_PIX * TB_DIV);
          check("pix_strobe_count", strb_n, e.cc * TB_PIX);
          check("done_busy_low", busy, 0);
          check("done_overrun", overrun, e.ovr);
        end
        sen_n = 0; acq_n = 0; strb_n = 0;
      end
    end
  end

  task automatic push_exp(input int cc, input int len, input logic ovr);
    exp_t e;
    e.start_cyc = cyc + 1;
    e.cc = cc; e.len = len; e.ovr = ovr;
    sb_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check(name, 1, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    longint s, t1, tdone;
    vecs[0] = '{16'd1, 11'd3, 1'b0, 0, 1'b0, 1, 56};
    vecs[1] = '{16'd2, 11'd0, 1'b0, 0, 1'b0, 2, 96};
    vecs[2] = '{16'd3, 11'd1, 1'b0, 0, 1'b0, 3, 144};
    vecs[3] = '{16'd0, 11'd2, 1'b0, 3, 1'b0, 3, 156};
    vecs[4] = '{16'd5, 11'd3, 1'b1, 0, 1'b0, 1, 56};
    vecs[5] = '{16'd0, 11'd5, 1'b1, 0, 1'b0, 1, 64};
    vecs[6] = '{16'd2, 11'd3, 1'b0, 0, 1'b1, 2, 112};

    sys_rst = 1'b1; start = 1'b0; stop = 1'b0; buf_ready = 1'b1;
    frames = 16'd0; int_ticks = 11'd0;
    start2 = 1'b0; frames2 = 16'd0; int_ticks2 = 11'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_sen_rst", sen_rst, 0);
    check("reset_acq_timing", acq_timing, 0);
    check("reset_count", count, 0);
    check("reset_data_count", data_count, 0);
    check("reset_cycle_count", cycle_count, 0);
    check("reset_flags", {pix_strobe, done, overrun}, 0);
    sys_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      wait_idle("vec_idle_timeout");
      frames = vecs[i].frames; int_ticks = vecs[i].int_ticks;
      stop = vecs[i].stop_w_start; start = 1'b1;
      push_exp(vecs[i].exp_cc, vecs[i].exp_len, 1'b0);
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      check("start_busy", busy, 1);
      check("start_sen_rst", sen_rst, 1);
      if (vecs[i].stop_frame > 0) begin
        n = 0;
        while (!(acq_timing && cycle_count == 32'(vecs[i].stop_frame - 1)) && n < 2000) begin
          @(negedge clk);
          n++;
        end
        if (n >= 2000) check("stop_wait_timeout", 1, 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
      end
      if (vecs[i].poke) begin
        repeat (10) @(negedge clk);
        frames = 16'd1; int_ticks = 11'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      @(negedge clk);
      wait_idle("vec_done_timeout");
    end

    // overrun on pixel 5, then cleared by the next start
    @(negedge clk);
    frames = 16'd1; int_ticks = 11'd1; start = 1'b1;
    push_exp(1, 48, OVR_EXP);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(acq_timing && data_count == 9'd5) && n < 200) begin
      @(negedge clk);
      n++;
    end
    buf_ready = 1'b0;
    n = 0;
    while (!pix_strobe && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ovr_strobe_index", data_count, 5);
    @(negedge clk);
    buf_ready = 1'b1;
    check("overrun_set", overrun, OVR_EXP);
    wait_idle("ovr_done_timeout");
    @(negedge clk);
    check("overrun_sticky_idle", overrun, OVR_EXP);
    frames = 16'd1; int_ticks = 11'd1; start = 1'b1;
    push_exp(1, 48, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("overrun_cleared", overrun, 0);
    @(negedge clk);
    wait_idle("ovr2_done_timeout");

    // abort during integration: everything zero next cycle, no done
    @(negedge clk);
    frames = 16'd0; int_ticks = 11'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(busy && !sen_rst && !acq_timing) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_integ", {busy, sen_rst, acq_timing}, 3'b100);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sen_rst", sen_rst, 0);
    check("abort_count", count, 0);
    check("abort_cycle_count", cycle_count, 0);
    check("abort_flags", {acq_timing, pix_strobe, done, overrun}, 0);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", busy, 0);

    // default parameters, int_ticks 0, two frames
    frames2 = 16'd2; int_ticks2 = 11'd0; start2 = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    t1 = -1; tdone = -1; n = 0;
    while (tdone < 0 && n < 30000) begin
      if (t1 < 0 && cycle_count2 == 32'd1) t1 = cyc - s;
      if (done2) tdone = cyc - s;
      @(negedge clk);
      n++;
    end
    check("def_frame_len", t1, 13425);
    check("def_done_latency", tdone, 26850);
    check("def_cycle_count", cycle_count2, 2);
    check("scoreboard_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
